// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: BYTES_PER_CYCLE inverse S-box lookups per cycle over a 128-bit state.
// Latency NUM_STEPS+1 cycles from acceptance to out_valid; result held while out_ready is low, no input accepted until drained.
module inv_sub_bytes_seq #(
    parameter  int BYTES_PER_CYCLE = 4,
    localparam int NUM_STEPS       = 16 / BYTES_PER_CYCLE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
        $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam int CW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_STEPS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    fsm_t          state;
    logic [CW-1:0] cnt;
    logic [127:0]  work;
    logic [127:0]  work_nxt;
    logic [127:0]  out_reg;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8), and naturally maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    always_comb begin
        work_nxt = work;
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
            int idx;
            idx = int'(cnt) * BYTES_PER_CYCLE + g;
            work_nxt[127-8*idx -: 8] = inv_sbox(work[127-8*idx -: 8]);
        end
    end

    // DONE spends its first cycle copying the finished working register to the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            out_reg   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= state_in;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    work <= work_nxt;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_reg   <= work;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign state_out = out_reg;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq at BYTES_PER_CYCLE 1, 4 and 16 against a table built by inverting the forward S-box.
module tb_inv_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         iv[3];
    logic         orr[3];
    logic [127:0] si[3];
    logic         ir[3];
    logic         ov[3];
    logic         bz[3];
    logic [127:0] so[3];

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .state_in(si[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .state_out(so[0]), .busy(bz[0]));
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .state_in(si[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .state_out(so[1]), .busy(bz[1]));
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .state_in(si[2]),
        .out_valid(ov[2]), .out_ready(orr[2]), .state_out(so[2]), .busy(bz[2]));

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] inv_tbl[256];

    typedef struct {
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;
    vec_t vecs[3];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        int r = 0;
        int x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x << 1;
            if (x & 'h100) x = x ^ 'h11b;
        end
        return r[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Forward S-box by brute-force inverse and affine map, then invert the table
    task automatic build_model();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] y = 8'h00;
            logic [7:0] s;
            for (int c = 1; c < 256; c++)
                if (mul(x[7:0], c[7:0]) == 8'h01) y = c[7:0];
            s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
            inv_tbl[s] = x[7:0];
        end
    endtask

    function automatic logic [127:0] ref_block(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tbl[d[127-8*i -: 8]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input int d, input logic [127:0] din, input int hold,
                             output logic [127:0] dout, output int lat);
        int w = 0;
        while (!ir[d] && w < 50) begin tick(); w++; end
        iv[d] = 1'b1;
        si[d] = din;
        tick();
        iv[d] = 1'b0;
        si[d] = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!ov[d] && lat < 200) begin tick(); lat++; end
        repeat (hold) tick();
        dout = so[d];
        orr[d] = 1'b1;
        tick();
        orr[d] = 1'b0;
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] snap;
        logic [127:0] blk;
        int lat;
        int steps;
        logic stable;
        logic spurious;

        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; orr[d] = 1'b0; si[d] = '0;
        end
        vecs[0] = '{128'h63636363_63636363_63636363_63636363, 128'h0};
        vecs[1] = '{128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'h00010203_04050607_08090a0b_0c0d0e0f};
        vecs[2] = '{128'h0016ed52_00000000_00000000_00000000, 128'h52ff5348_52525252_52525252_52525252};
        build_model();

        #12;
        check("reset_in_ready", 128'(ir[1]), 128'd1);
        check("reset_out_valid", 128'(ov[1]), 128'd0);
        check("reset_busy", 128'(bz[1]), 128'd0);
        check("reset_state_out", so[1], 128'h0);
        rst_n = 1'b1;
        tick();

        for (int d = 0; d < 3; d++) begin
            steps = (d == 0) ? 16 : (d == 1) ? 4 : 1;
            for (int v = 0; v < 3; v++) begin
                run_block(d, vecs[v].din, 0, res, lat);
                check($sformatf("vec%0d_bpc_dut%0d", v, d), res, vecs[v].dexp);
                check($sformatf("lat%0d_dut%0d", v, d), 128'(lat), 128'(steps + 1));
            end
        end

        for (int k = 0; k < 16; k++) begin
            for (int b = 0; b < 16; b++) blk[127-8*b -: 8] = 8'(16 * k + b);
            run_block(1, blk, 0, res, lat);
            check($sformatf("exhaustive_blk%0d", k), res, ref_block(blk));
        end

        for (int k = 0; k < 12; k++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            run_block(k % 3, blk, int'($urandom_range(0, 3)), res, lat);
            check($sformatf("random%0d", k), res, ref_block(blk));
        end

        // Backpressure: hold the result for 10 cycles and poke in_valid meanwhile
        iv[1] = 1'b1; si[1] = vecs[1].din;
        tick();
        iv[1] = 1'b0;
        lat = 0;
        while (!ov[1] && lat < 200) begin tick(); lat++; end
        snap = so[1];
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!ov[1] || so[1] !== snap || ir[1]) stable = 1'b0;
            if (i == 3) begin iv[1] = 1'b1; si[1] = {$urandom, $urandom, $urandom, $urandom}; end
            if (i == 4) iv[1] = 1'b0;
            tick();
        end
        check("bp_stable", 128'(stable), 128'd1);
        check("bp_data", snap, vecs[1].dexp);
        orr[1] = 1'b1;
        tick();
        orr[1] = 1'b0;
        check("bp_release_out_valid", 128'(ov[1]), 128'd0);
        check("bp_release_in_ready", 128'(ir[1]), 128'd1);
        check("bp_hold_state_out", so[1], vecs[1].dexp);
        blk = {$urandom, $urandom, $urandom, $urandom};
        run_block(1, blk, 0, res, lat);
        check("bp_next_block", res, ref_block(blk));

        // Reset during BUSY step 2
        iv[1] = 1'b1; si[1] = vecs[1].din;
        tick();
        iv[1] = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 128'(ov[1]), 128'd0);
        check("rst_in_ready", 128'(ir[1]), 128'd1);
        check("rst_busy", 128'(bz[1]), 128'd0);
        check("rst_state_out", so[1], 128'h0);
        tick();
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ov[1] || !ir[1]) spurious = 1'b1;
            tick();
        end
        check("rst_no_spurious", 128'(spurious), 128'd0);
        run_block(1, vecs[1].din, 0, res, lat);
        check("rst_next_block", res, vecs[1].dexp);
        check("rst_next_lat", 128'(lat), 128'd5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
